// File: rtl/stream_pkg.sv
// Shared types and default constants for the S/PDIF stream controller.
// State encoding is common to the RTL and anything that observes it.
package stream_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_QUALIFY,
        ST_PREFILL,
        ST_RUN,
        ST_RECOVER
    } state_t;

    localparam int DEPTH_DEF          = 16;
    localparam int PREFILL_DEF        = 8;
    localparam int LOCK_FRAMES_DEF    = 4;
    localparam int FCLK_MIN_DEF       = 60;
    localparam int FCLK_MAX_DEF       = 68;
    localparam int RECOVER_CYCLES_DEF = 16;

endpackage

// File: rtl/fclk_monitor.sv
// Frame clock synchronizer, rising-edge detector and period checker.
// Edge pulse lands 3 clk cycles after fclk is first sampled high.
module fclk_monitor
    import stream_pkg::*;
#(
    parameter int FCLK_MIN = FCLK_MIN_DEF,
    parameter int FCLK_MAX = FCLK_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic fclk,
    output logic edge_pulse,
    output logic legal,
    output logic illegal,
    output logic overtime
);

    localparam logic [7:0] MIN_L = 8'(FCLK_MIN);
    localparam logic [7:0] MAX_L = 8'(FCLK_MAX);

    logic [1:0] sync;
    logic       prev;
    logic [7:0] period;
    logic       in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            prev       <= 1'b0;
            edge_pulse <= 1'b0;
            period     <= '0;
        end else begin
            sync       <= {sync[0], fclk};
            prev       <= sync[1];
            edge_pulse <= sync[1] & ~prev;
            if (edge_pulse)
                period <= '0;
            else if (period != 8'hFF)
                period <= period + 8'd1;
        end
    end

    assign in_range = (period >= MIN_L) && (period <= MAX_L);
    assign legal    = edge_pulse & in_range;
    assign illegal  = edge_pulse & ~in_range;
    assign overtime = period > MAX_L;

endmodule

// File: rtl/stream_controller.sv
// Playback controller: qualifies the I2S frame clock, prefills the FIFO,
// streams to the S/PDIF transmitter and recovers from faults.
module stream_controller
    import stream_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEF,
    parameter int PREFILL        = PREFILL_DEF,
    parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF,
    parameter int FCLK_MIN       = FCLK_MIN_DEF,
    parameter int FCLK_MAX       = FCLK_MAX_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       fclk,
    input  logic       frame_req,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       fifo_write_en,
    output logic       fifo_read_en,
    output logic       datapath_rst,
    output logic       validity,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [7:0] fault_count
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(LOCK_FRAMES + 1);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    localparam logic [FW-1:0] LOCK_L    = FW'(LOCK_FRAMES);
    localparam logic [RW-1:0] RLAST     = RW'(RECOVER_CYCLES - 1);

    state_t          state, state_n;
    logic [LW-1:0]   level, level_n;
    logic [FW-1:0]   frame_cnt, frame_n;
    logic [RW-1:0]   rec_cnt, rec_n;
    logic            wr_c, rd_c, fault;
    logic            edge_pulse, legal, illegal, overtime;
    logic            period_bad, overrun, underrun;

    fclk_monitor #(
        .FCLK_MIN(FCLK_MIN),
        .FCLK_MAX(FCLK_MAX)
    ) u_mon (
        .clk       (clk),
        .rst       (rst),
        .fclk      (fclk),
        .edge_pulse(edge_pulse),
        .legal     (legal),
        .illegal   (illegal),
        .overtime  (overtime)
    );

    assign period_bad = illegal | overtime;
    assign overrun    = edge_pulse & (fifo_full | (level == DEPTH_L));
    assign underrun   = frame_req & (fifo_empty | (level == '0));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_HOLD;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        level_n = level;
        frame_n = '0;
        rec_n   = '0;
        wr_c    = 1'b0;
        rd_c    = 1'b0;
        fault   = 1'b0;
        unique case (state)
            ST_HOLD: state_n = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (pll_lock)
                    state_n = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                frame_n = frame_cnt;
                if (!pll_lock)
                    fault = 1'b1;
                else if (period_bad)
                    frame_n = '0;
                else if (legal) begin
                    frame_n = frame_cnt + FW'(1);
                    if (frame_n == LOCK_L)
                        state_n = ST_PREFILL;
                end
            end
            ST_PREFILL, ST_RUN: begin
                // Priority: lock loss, period fault, overrun, underrun.
                if (!pll_lock || period_bad || overrun)
                    fault = 1'b1;
                else if (state == ST_RUN && underrun)
                    fault = 1'b1;
                else begin
                    wr_c = edge_pulse;
                    rd_c = (state == ST_RUN) && frame_req;
                    if (wr_c && !rd_c)
                        level_n = level + LW'(1);
                    else if (rd_c && !wr_c)
                        level_n = level - LW'(1);
                    if (state == ST_PREFILL && level_n >= PREFILL_L)
                        state_n = ST_RUN;
                end
            end
            ST_RECOVER: begin
                level_n = '0;
                rec_n   = rec_cnt + RW'(1);
                if (rec_cnt == RLAST)
                    state_n = ST_WAIT_LOCK;
            end
            default: state_n = ST_HOLD;
        endcase
        if (fault) begin
            state_n = ST_RECOVER;
            level_n = '0;
            frame_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level         <= '0;
            frame_cnt     <= '0;
            rec_cnt       <= '0;
            fault_count   <= '0;
            fifo_write_en <= 1'b0;
            fifo_read_en  <= 1'b0;
            datapath_rst  <= 1'b1;
            validity      <= 1'b0;
            red           <= 1'b0;
            green         <= 1'b1;
            blue          <= 1'b1;
        end else begin
            level         <= level_n;
            frame_cnt     <= frame_n;
            rec_cnt       <= rec_n;
            fifo_write_en <= wr_c;
            fifo_read_en  <= rd_c;
            datapath_rst  <= state_n inside {ST_HOLD, ST_WAIT_LOCK, ST_RECOVER};
            validity      <= state_n == ST_RUN;
            red           <= !(state_n inside {ST_HOLD, ST_WAIT_LOCK, ST_RECOVER});
            blue          <= !(state_n inside {ST_QUALIFY, ST_PREFILL});
            green         <= state_n != ST_RUN;
            if (fault && fault_count != 8'hFF)
                fault_count <= fault_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_stream_controller.sv
// Directed bench for stream_controller: bring-up, steady streaming and
// each recovery path, with hand-computed expectations.
module tb_stream_controller;
    import stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       fclk = 1'b0;
    logic       frame_req = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       fifo_write_en, fifo_read_en, datapath_rst, validity;
    logic       red, green, blue;
    logic [7:0] fault_count;

    int errors = 0;
    int checks = 0;
    bit fclk_en = 1'b1;
    int short_req = 0;

    stream_controller dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .fclk         (fclk),
        .frame_req    (frame_req),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_write_en(fifo_write_en),
        .fifo_read_en (fifo_read_en),
        .datapath_rst (datapath_rst),
        .validity     (validity),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    // Frame clock: period 64 clk cycles, one 50-cycle period per short_req.
    initial begin : fclk_gen
        int cnt;
        int cur;
        int short_done;
        cnt = 0;
        cur = 64;
        short_done = 0;
        forever begin
            @(negedge clk);
            if (!fclk_en) begin
                fclk = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) fclk = 1'b1;
                if (cnt == cur / 2) fclk = 1'b0;
                cnt++;
                if (cnt == cur) begin
                    cnt = 0;
                    if (short_req != short_done) begin
                        cur = 50;
                        short_done++;
                    end else begin
                        cur = 64;
                    end
                end
            end
        end
    end

    task automatic wait_state(input state_t s, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (dut.state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.state !== ST_HOLD) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_HOLD);
        end
        checks++;
        if ({datapath_rst, red, green, blue, validity, fifo_write_en, fifo_read_en} !== 7'b1011000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 1011000",
                     {datapath_rst, red, green, blue, validity, fifo_write_en, fifo_read_en});
        end
        checks++;
        if (fault_count !== 8'd0 || dut.level !== 0) begin
            errors++;
            $display("FAIL reset_counts: got fc=%0d lvl=%0d expected 0 0", fault_count, dut.level);
        end
    endtask

    task automatic test_bringup;
        bit ok;
        int n;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== ST_WAIT_LOCK || datapath_rst !== 1'b1) begin
            errors++;
            $display("FAIL wait_lock: got st=%0d dr=%b expected %0d 1", dut.state, datapath_rst, ST_WAIT_LOCK);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== ST_QUALIFY || {datapath_rst, red, green, blue} !== 4'b0110) begin
            errors++;
            $display("FAIL qualify_entry: got st=%0d leds=%b expected %0d 0110",
                     dut.state, {datapath_rst, red, green, blue}, ST_QUALIFY);
        end
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_read_en !== 1'b0 || fault_count !== 8'd0 || dut.state !== ST_QUALIFY) begin
            errors++;
            $display("FAIL frame_req_ignored: got rd=%b fc=%0d st=%0d expected 0 0 %0d",
                     fifo_read_en, fault_count, dut.state, ST_QUALIFY);
        end
        wait_state(ST_PREFILL, 64 * 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reach_prefill: got timeout expected PREFILL");
        end
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 64 * 12; i++) begin
            @(negedge clk);
            if (fifo_write_en) n++;
            if (dut.state == ST_RUN) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || n != 8) begin
            errors++;
            $display("FAIL prefill_writes: got ok=%b writes=%0d expected 1 8", ok, n);
        end
        checks++;
        if (dut.level !== 8 || {green, validity, red, blue} !== 4'b0111) begin
            errors++;
            $display("FAIL run_entry: got lvl=%0d gvrb=%b expected 8 0111",
                     dut.level, {green, validity, red, blue});
        end
    endtask

    task automatic test_steady;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (fifo_write_en) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok || dut.level !== 9) begin
                errors++;
                $display("FAIL steady_write%0d: got ok=%b lvl=%0d expected 1 9", k, ok, dut.level);
            end
            repeat (10) @(negedge clk);
            frame_req = 1'b1;
            @(negedge clk);
            frame_req = 1'b0;
            checks++;
            if (fifo_read_en !== 1'b1) begin
                errors++;
                $display("FAIL steady_read%0d: got %b expected 1", k, fifo_read_en);
            end
            @(negedge clk);
            checks++;
            if (fifo_read_en !== 1'b0 || dut.level !== 8) begin
                errors++;
                $display("FAIL steady_level%0d: got rd=%b lvl=%0d expected 0 8", k, fifo_read_en, dut.level);
            end
        end
    endtask

    task automatic test_underrun;
        bit hit;
        int lvl_before;
        int n;
        hit = 1'b0;
        lvl_before = -1;
        for (int i = 0; i < 40; i++) begin
            lvl_before = int'(dut.level);
            frame_req = 1'b1;
            @(negedge clk);
            frame_req = 1'b0;
            if (dut.state == ST_RECOVER) begin
                hit = 1'b1;
                break;
            end
            repeat (31) @(negedge clk);
        end
        checks++;
        if (!hit || lvl_before != 0) begin
            errors++;
            $display("FAIL underrun_hit: got hit=%b lvl=%0d expected 1 0", hit, lvl_before);
        end
        checks++;
        if (fault_count !== 8'd1 || {red, datapath_rst, validity, fifo_read_en} !== 4'b0100) begin
            errors++;
            $display("FAIL underrun_outputs: got fc=%0d rdvr=%b expected 1 0100",
                     fault_count, {red, datapath_rst, validity, fifo_read_en});
        end
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.state != ST_RECOVER) break;
            n++;
        end
        checks++;
        if (n != 16 || dut.state !== ST_WAIT_LOCK) begin
            errors++;
            $display("FAIL recover_len: got n=%0d st=%0d expected 16 %0d", n, dut.state, ST_WAIT_LOCK);
        end
    endtask

    task automatic test_fclk_stop;
        bit ok;
        int n;
        wait_state(ST_RUN, 64 * 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rerun: got timeout expected RUN");
        end
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (fifo_write_en) begin
                ok = 1'b1;
                break;
            end
        end
        fclk_en = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (dut.state == ST_RECOVER) break;
        end
        checks++;
        if (!ok || n != 70 || fault_count !== 8'd2) begin
            errors++;
            $display("FAIL fclk_stop: got ok=%b n=%0d fc=%0d expected 1 70 2", ok, n, fault_count);
        end
        fclk_en = 1'b1;
        wait_state(ST_QUALIFY, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL requalify: got timeout expected QUALIFY");
        end
    endtask

    task automatic test_short_period;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 * 6; i++) begin
            @(negedge clk);
            if (dut.frame_cnt == 1) begin
                ok = 1'b1;
                break;
            end
        end
        short_req++;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_cnt_one: got timeout expected 1");
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut.state != ST_QUALIFY) break;
            if (dut.frame_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || dut.state !== ST_QUALIFY) begin
            errors++;
            $display("FAIL short_restart: got ok=%b st=%0d cnt=%0d expected 1 %0d 0",
                     ok, dut.state, dut.frame_cnt, ST_QUALIFY);
        end
        wait_state(ST_PREFILL, 64 * 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prefill_after_short: got timeout expected PREFILL");
        end
    endtask

    task automatic test_dual_fault;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (dut.edge_pulse) begin
                ok = 1'b1;
                break;
            end
        end
        pll_lock = 1'b0;
        fifo_full = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || dut.state !== ST_RECOVER || fault_count !== 8'd3 || fifo_write_en !== 1'b0) begin
            errors++;
            $display("FAIL dual_fault: got ok=%b st=%0d fc=%0d wr=%b expected 1 %0d 3 0",
                     ok, dut.state, fault_count, fifo_write_en, ST_RECOVER);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (fault_count !== 8'd3) begin
            errors++;
            $display("FAIL dual_single_inc: got %0d expected 3", fault_count);
        end
        pll_lock = 1'b1;
        fifo_full = 1'b0;
    endtask

    task automatic test_rst_mid_run;
        bit ok;
        wait_state(ST_RUN, 64 * 20, ok);
        checks++;
        if (!ok || dut.level !== 8) begin
            errors++;
            $display("FAIL run_before_rst: got ok=%b lvl=%0d expected 1 8", ok, dut.level);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dut.state !== ST_HOLD || dut.level !== 0) begin
            errors++;
            $display("FAIL rst_mid_state: got st=%0d lvl=%0d expected %0d 0", dut.state, dut.level, ST_HOLD);
        end
        checks++;
        if ({fifo_write_en, fifo_read_en, datapath_rst, validity, red, green, blue} !== 7'b0010011
            || fault_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b fc=%0d expected 0010011 0",
                     {fifo_write_en, fifo_read_en, datapath_rst, validity, red, green, blue}, fault_count);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_steady();
        test_underrun();
        test_fclk_stop();
        test_short_period();
        test_dual_fault();
        test_rst_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
